serial_adder: RTL

Parametrised bit-serial adder/subtractor that processes two WIDTH-bit operands one bit per cycle, LSB first, through a single full-adder cell and a registered carry. It extends the team's combinational half-adder cells into a sequential arithmetic unit for area-constrained datapaths. It trades latency for a one-bit datapath and connects to producers and consumers through valid/ready handshakes on both sides.

---
 rtl/serial_adder.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor with valid/ready handshakes
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int               CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_s;
  logic             w_c;
  logic             w_last;

  // Single full-adder cell working on the current LSBs and the carry register
  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last = (r_cnt == CNT_LAST);

  // Handshake flags are pure state decodes, so no path from in_valid/out_ready
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

  // Control FSM plus serial datapath; result registers update only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with sub
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_c   <= w_c;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_s, r_res[WIDTH-1:1]};
          if (w_last) begin
            // r_c still holds the carry into the MSB at this point
            r_sum       <= {w_s, r_res[WIDTH-1:1]};
            r_carry_out <= w_c;
            r_overflow  <= r_c ^ w_c;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
